// File: rtl/rr_hold_arbiter.sv
// rr_hold_arbiter
//   Round-robin arbiter with grant hold. A granted requester keeps its grant
//   for a tenure. The tenure ends when its request drops, when it marks its
//   final cycle with last, or when it has held the grant for MAX_HOLD cycles.
//   At the end of a tenure the pointer moves past the holder, and the next
//   winner is granted on the following cycle with no idle bubble.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous, active-high reset
//   req[SIZE]      per-requester request, bit i = requester i
//   last           holder's final-cycle marker, only looked at while granted
//   gnt[SIZE]      registered one-hot grant, zero when idle
//   gnt_valid      registered, equals |gnt
//   gnt_idx        registered binary index of the grant, zero when idle
//   dbg_state_o    FSM state (0 = IDLE, 1 = GRANT)
//   dbg_ptr_o      round-robin pointer (highest-priority index)
//   dbg_hold_o     cycles already held in the current tenure, minus one
//
// Grant/last handshake: gnt_valid acts as the valid and the holder's request
// acts as the ready. A tenure cycle completes on every edge where gnt_valid=1.
// The holder closes the tenure by presenting last=1, or by dropping its
// request, in a cycle where gnt_valid=1. Outside gnt_valid=1, last is ignored.
module rr_hold_arbiter #(
  parameter int SIZE     = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SIZE-1:0]           req,
  input  logic                      last,
  output logic [SIZE-1:0]           gnt,
  output logic                      gnt_valid,
  output logic [$clog2(SIZE)-1:0]   gnt_idx,
  output logic                      dbg_state_o,
  output logic [$clog2(SIZE)-1:0]   dbg_ptr_o,
  output logic [((MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1)-1:0] dbg_hold_o
);

  localparam int IW = $clog2(SIZE);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [SIZE-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            vld_q, vld_d;

  logic            tenure_end;
  logic [IW-1:0]   next_ptr;
  logic [IW-1:0]   arb_base;
  logic            win_found;
  logic [IW-1:0]   win_idx;
  int              cand;

  // Arbitration. At a tenure end the scan already starts from the advanced
  // pointer, so the old holder falls to lowest priority for the new winner.
  always_comb begin
    tenure_end = (state_q == GRANT) &&
                 (!req[idx_q] || last || (hold_cnt_q == HW'(MAX_HOLD - 1)));
    next_ptr   = (idx_q == IW'(SIZE - 1)) ? '0 : idx_q + IW'(1);
    arb_base   = tenure_end ? next_ptr : ptr_q;
    win_found  = 1'b0;
    win_idx    = '0;
    cand       = 0;
    for (int i = 0; i < SIZE; i++) begin
      cand = (int'(arb_base) + i) % SIZE;
      if (!win_found && req[IW'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IW'(cand);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      idx_q      <= '0;
      vld_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      idx_q      <= idx_d;
      vld_q      <= vld_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    idx_d      = idx_q;
    vld_d      = vld_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d    = GRANT;
          gnt_d      = {{(SIZE-1){1'b0}}, 1'b1} << win_idx;
          idx_d      = win_idx;
          vld_d      = 1'b1;
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        if (tenure_end) begin
          ptr_d = next_ptr;
          if (win_found) begin
            gnt_d      = {{(SIZE-1){1'b0}}, 1'b1} << win_idx;
            idx_d      = win_idx;
            vld_d      = 1'b1;
            hold_cnt_d = '0;
          end else begin
            state_d    = IDLE;
            gnt_d      = '0;
            idx_d      = '0;
            vld_d      = 1'b0;
            hold_cnt_d = '0;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    gnt         = gnt_q;
    gnt_valid   = vld_q;
    gnt_idx     = idx_q;
    dbg_state_o = state_q;
    dbg_ptr_o   = ptr_q;
    dbg_hold_o  = hold_cnt_q;
  end

endmodule
